// File: rtl/ula_multiciclo.sv
// ula_multiciclo: LARGURA-bit registered ALU with start/done handshake, shift-add MUL and restoring DIV.
// Define ULA_DIV_EN to build the divider; without it opcode 13 completes as an invalid operation.
module ula_multiciclo #(
   parameter int LARGURA = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [LARGURA-1:0]     entradaA,
   input  logic [LARGURA-1:0]     entradaB,
   input  logic [3:0]             opCode,
   input  logic                   inicio,
   output logic                   ocupado,
   output logic                   pronto,
   output logic [2*LARGURA-1:0]   saida,
   output logic                   zero,
   output logic                   erro
);
   localparam int CW = $clog2(LARGURA) + 1;
   localparam int W2 = 2 * LARGURA;
   typedef enum logic [1:0] {
      OCIOSO,
      MULT
`ifdef ULA_DIV_EN
      , DIVI
`endif
   } estado_t;
   estado_t             estado_q, estado_d;
   logic [LARGURA-1:0]  a_q, a_d;
   logic [W2-1:0]       p_q, p_d, saida_q, saida_d, uni_res, mul_p;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                pronto_q, pronto_d, zero_q, zero_d, erro_q, erro_d, uni_err, ultimo;
   logic [LARGURA:0]    soma, dif, soma_m;
`ifdef ULA_DIV_EN
   logic [LARGURA-1:0]  b_q, b_d;
   logic [LARGURA:0]    resto_t, dif_d;
   logic [W2-1:0]       div_p;
`endif
   always_comb begin
      soma    = {1'b0, entradaA} + {1'b0, entradaB};
      dif     = {1'b0, entradaA} - {1'b0, entradaB};
      uni_res = '0;
      uni_err = 1'b0;
      case (opCode)
         4'd0:  uni_res = W2'(soma);
         4'd1:  uni_res = W2'(dif);
         4'd2:  uni_res[0] = entradaA > entradaB;
         4'd3:  uni_res[0] = entradaA < entradaB;
         4'd4:  uni_res[0] = entradaA >= entradaB;
         4'd5:  uni_res[0] = entradaA <= entradaB;
         4'd6:  uni_res[0] = entradaA == entradaB;
         4'd7:  uni_res[LARGURA-1:0] = ~entradaA;
         4'd8:  uni_res[LARGURA-1:0] = entradaA & entradaB;
         4'd9:  uni_res[LARGURA-1:0] = entradaA | entradaB;
         4'd10: uni_res[LARGURA-1:0] = entradaA ^ entradaB;
         4'd11: uni_res[LARGURA-1:0] = ~(entradaA ^ entradaB);
`ifdef ULA_DIV_EN
         4'd13: begin
            uni_res = {entradaA, {LARGURA{1'b1}}};
            uni_err = 1'b1;
         end
`endif
         default: uni_err = 1'b1;
      endcase
   end
   // Multiply: upper half accumulates, whole register shifts right each step.
   assign soma_m = {1'b0, p_q[W2-1:LARGURA]} + (p_q[0] ? {1'b0, a_q} : '0);
   assign mul_p  = {soma_m, p_q[LARGURA-1:1]};
`ifdef ULA_DIV_EN
   assign resto_t = {p_q[W2-1:LARGURA], p_q[LARGURA-1]};
   assign dif_d   = resto_t - {1'b0, b_q};
   assign div_p   = {dif_d[LARGURA] ? resto_t[LARGURA-1:0] : dif_d[LARGURA-1:0],
                     p_q[LARGURA-2:0], ~dif_d[LARGURA]};
`endif
   assign ultimo = cnt_q == CW'(LARGURA - 1);
   always_comb begin
      estado_d = estado_q;
      a_d      = a_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      saida_d  = saida_q;
      erro_d   = erro_q;
      pronto_d = 1'b0;
`ifdef ULA_DIV_EN
      b_d      = b_q;
`endif
      case (estado_q)
         OCIOSO: if (inicio) begin
            a_d   = entradaA;
            cnt_d = '0;
`ifdef ULA_DIV_EN
            b_d   = entradaB;
`endif
            if (opCode == 4'd12) begin
               estado_d = MULT;
               p_d      = {{LARGURA{1'b0}}, entradaB};
            end
`ifdef ULA_DIV_EN
            else if (opCode == 4'd13 && entradaB != '0) begin
               estado_d = DIVI;
               p_d      = {{LARGURA{1'b0}}, entradaA};
            end
`endif
            else begin
               saida_d  = uni_res;
               erro_d   = uni_err;
               pronto_d = 1'b1;
            end
         end
         MULT: begin
            p_d   = mul_p;
            cnt_d = cnt_q + CW'(1);
            if (ultimo) begin
               estado_d = OCIOSO;
               saida_d  = mul_p;
               erro_d   = 1'b0;
               pronto_d = 1'b1;
            end
         end
`ifdef ULA_DIV_EN
         DIVI: begin
            p_d   = div_p;
            cnt_d = cnt_q + CW'(1);
            if (ultimo) begin
               estado_d = OCIOSO;
               saida_d  = div_p;
               erro_d   = 1'b0;
               pronto_d = 1'b1;
            end
         end
`endif
         default: estado_d = OCIOSO;
      endcase
      zero_d = pronto_d ? (saida_d == '0) : zero_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         a_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         saida_q  <= '0;
         erro_q   <= 1'b0;
         zero_q   <= 1'b0;
         pronto_q <= 1'b0;
`ifdef ULA_DIV_EN
         b_q      <= '0;
`endif
      end else begin
         estado_q <= estado_d;
         a_q      <= a_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         saida_q  <= saida_d;
         erro_q   <= erro_d;
         zero_q   <= zero_d;
         pronto_q <= pronto_d;
`ifdef ULA_DIV_EN
         b_q      <= b_d;
`endif
      end
   end
   assign ocupado = estado_q != OCIOSO;
   assign pronto  = pronto_q;
   assign saida   = saida_q;
   assign zero    = zero_q;
   assign erro    = erro_q;
endmodule
